issue_scheduler: RTL and testbench

//   In-order issue controller between decode and execute. Consumes decode

---
 rtl/issue_scheduler_if.sv | 39 +++
 rtl/issue_scheduler.sv | 120 ++++++++++++
 tb/tb_issue_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/issue_scheduler_if.sv
// Decode/execute handshake bundle for the in-order issue scheduler.
//   dec_valid             decode holds a valid instruction
//   dec_src1 / dec_src2   instruction reads rs / rt
//   dec_dest              instruction writes a GPR (dec_wr)
//   dec_load              instruction is a load (LW/LB/LBU)
//   dec_div               instruction is DIV/DIVU
//   dec_hilo              instruction is MFHI/MFLO
//   dec_rs/dec_rt/dec_wr  source 1, source 2 and destination register numbers
//   ex_ready              execute stage accepts an instruction this cycle
//   issue                 instruction moves decode->execute this cycle
//   stall                 valid instruction held in decode this cycle
// master: the decode/execute side driving the request; slave: the scheduler.
interface issue_scheduler_if;
    logic       dec_valid;
    logic       dec_src1;
    logic       dec_src2;
    logic       dec_dest;
    logic       dec_load;
    logic       dec_div;
    logic       dec_hilo;
    logic [4:0] dec_rs;
    logic [4:0] dec_rt;
    logic [4:0] dec_wr;
    logic       ex_ready;
    logic       issue;
    logic       stall;

    modport master (
        output dec_valid, dec_src1, dec_src2, dec_dest, dec_load, dec_div, dec_hilo,
        output dec_rs, dec_rt, dec_wr, ex_ready,
        input  issue, stall
    );

    modport slave (
        input  dec_valid, dec_src1, dec_src2, dec_dest, dec_load, dec_div, dec_hilo,
        input  dec_rs, dec_rt, dec_wr, ex_ready,
        output issue, stall
    );
endinterface

// File: rtl/issue_scheduler.sv
// In-order issue controller between decode and execute. A per-register
// scoreboard blocks RAW/WAW hazards, a busy counter sequences the multi-cycle
// divider against DIV and MFHI/MFLO, and stall cycles are counted.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous reset, active low
//   bus        issue_scheduler_if.slave (decode flags, ex_ready, issue, stall)
//   div_busy   divider sequence in progress (registered)
//   stall_cnt  saturating count of stall cycles (registered)
module issue_scheduler #(
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned DIV_LAT  = 32,
    parameter int unsigned CNT_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    issue_scheduler_if.slave      bus,
    output logic                  div_busy,
    output logic [31:0]           stall_cnt
);

    localparam int unsigned DivW = $clog2(DIV_LAT + 1);

    localparam logic [CNT_W-1:0] AluNew  = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] LoadNew = CNT_W'(LOAD_LAT - 1);
    localparam logic [DivW-1:0]  DivLat  = DivW'(DIV_LAT);

    // Register 0 is hardwired and never tracked.
    logic [CNT_W-1:0] sb_q [1:31];
    logic [CNT_W-1:0] sb_d [1:31];
    logic [DivW-1:0]  div_cnt_q, div_cnt_d;
    logic             div_busy_q, div_busy_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic [CNT_W-1:0] cnt_rs, cnt_rt, cnt_wr;
    logic [CNT_W-1:0] newlat;
    logic             raw1, raw2, waw, dvh;
    logic             issue_w, stall_w;

    // Scoreboard lookups; an index of 0 leaves the lookup at zero.
    always_comb begin
        cnt_rs = '0;
        cnt_rt = '0;
        cnt_wr = '0;
        for (int r = 1; r < 32; r++) begin
            if (bus.dec_rs == 5'(r)) cnt_rs = sb_q[r];
            if (bus.dec_rt == 5'(r)) cnt_rt = sb_q[r];
            if (bus.dec_wr == 5'(r)) cnt_wr = sb_q[r];
        end
    end

    always_comb begin
        newlat  = bus.dec_load ? LoadNew : AluNew;
        raw1    = bus.dec_src1 & (bus.dec_rs != 5'd0) & (cnt_rs != '0);
        raw2    = bus.dec_src2 & (bus.dec_rt != 5'd0) & (cnt_rt != '0);
        // A newer write must not complete before an older in-flight one.
        waw     = bus.dec_dest & (bus.dec_wr != 5'd0) & (cnt_wr > newlat);
        dvh     = (bus.dec_div | bus.dec_hilo) & div_busy_q;
        issue_w = rst_n & bus.dec_valid & bus.ex_ready & ~(raw1 | raw2 | waw | dvh);
        stall_w = rst_n & bus.dec_valid & ~issue_w;
    end

    assign bus.issue = issue_w;
    assign bus.stall = stall_w;

    // Scoreboard: frozen with the pipeline when ex_ready is low; an issuing
    // write overrides the decrement of its own destination.
    always_comb begin
        for (int r = 1; r < 32; r++) begin
            sb_d[r] = sb_q[r];
            if (bus.ex_ready && sb_q[r] != '0) begin
                sb_d[r] = sb_q[r] - 1'b1;
            end
            if (issue_w && bus.dec_dest && bus.dec_wr == 5'(r)) begin
                sb_d[r] = newlat;
            end
        end
    end

    // Divider counts down in real time, independent of ex_ready.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (issue_w && bus.dec_div) begin
            div_cnt_d = DivLat;
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end
        div_busy_d = (div_cnt_d != '0);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 1; r < 32; r++) begin
                sb_q[r] <= '0;
            end
            div_cnt_q   <= '0;
            div_busy_q  <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                sb_q[r] <= sb_d[r];
            end
            div_cnt_q   <= div_cnt_d;
            div_busy_q  <= div_busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign div_busy  = div_busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_issue_scheduler;

    logic        clk;
    logic        rst_n;
    logic        div_busy;
    logic [31:0] stall_cnt;
    int          total;
    int          bad;
    int          n;

    issue_scheduler_if bus ();

    issue_scheduler #(
        .ALU_LAT  (1),
        .LOAD_LAT (2),
        .DIV_LAT  (32),
        .CNT_W    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .div_busy  (div_busy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s1, input logic s2, input logic d,
                         input logic ld, input logic dv, input logic hl,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr);
        bus.dec_valid = v;
        bus.dec_src1  = s1;
        bus.dec_src2  = s2;
        bus.dec_dest  = d;
        bus.dec_load  = ld;
        bus.dec_div   = dv;
        bus.dec_hilo  = hl;
        bus.dec_rs    = rs;
        bus.dec_rt    = rt;
        bus.dec_wr    = wr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic expect_is(input string tag, input logic exp_issue, input logic exp_stall);
        @(negedge clk);
        check_eq({tag, "_issue"}, {31'd0, bus.issue}, {31'd0, exp_issue});
        check_eq({tag, "_stall"}, {31'd0, bus.stall}, {31'd0, exp_stall});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.ex_ready = 1'b1;

        // Reset: valid, hazard-free instruction must still not issue or stall.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
        expect_is("rst", 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        check_eq("rst_div_busy", {31'd0, div_busy}, 32'd0);
        check_eq("rst_stall_cnt", stall_cnt, 32'd0);
        cyc();
        rst_n = 1'b1;
        idle();
        expect_is("idle", 1'b0, 1'b0);

        // 1: ADDU r3<-r1,r2 ; ADDU r4<-r3,r3 back to back.
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
        expect_is("t1_addu_a", 1'b1, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd3, 5'd4);
        expect_is("t1_addu_b", 1'b1, 1'b0);
        cyc();
        idle();
        @(negedge clk);
        check_eq("t1_stall_cnt", stall_cnt, 32'd0);

        // 2: LW r5 ; ADDU r6<-r5,r0 -> one bubble.
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
        expect_is("t2_lw", 1'b1, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd6);
        expect_is("t2_use_wait", 1'b0, 1'b1);
        cyc();
        expect_is("t2_use_go", 1'b1, 1'b0);
        cyc();
        idle();
        @(negedge clk);
        check_eq("t2_stall_cnt", stall_cnt, 32'd1);

        // 3: DIV r1,r2 ; MFLO r7 -> 32 stall cycles.
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0);
        expect_is("t3_div", 1'b1, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7);
        n = 0;
        @(negedge clk);
        check_eq("t3_busy_on", {31'd0, div_busy}, 32'd1);
        while (!bus.issue && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq("t3_mflo_stalls", n, 32'd32);
        check_eq("t3_busy_off", {31'd0, div_busy}, 32'd0);
        cyc();
        idle();
        @(negedge clk);
        check_eq("t3_stall_cnt", stall_cnt, 32'd33);

        // 4: LW r8 ; freeze 3 cycles ; ADDU r10<-r8 stalls once after thaw.
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd8);
        expect_is("t4_lw", 1'b1, 1'b0);
        cyc();
        bus.ex_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd11);
        expect_is("t4_frozen", 1'b0, 1'b1);
        cyc();
        idle();
        expect_is("t4_frozen_idle", 1'b0, 1'b0);
        cyc();
        cyc();
        bus.ex_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 5'd10);
        expect_is("t4_use_wait", 1'b0, 1'b1);
        cyc();
        expect_is("t4_use_go", 1'b1, 1'b0);
        cyc();
        idle();
        @(negedge clk);
        check_eq("t4_stall_cnt", stall_cnt, 32'd35);

        // 5: LW r0 ; ADDU r9<-r0,r0 -> r0 never hazards.
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0);
        expect_is("t5_lw_r0", 1'b1, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
        expect_is("t5_use_r0", 1'b1, 1'b0);

        // WAW: LW r12 ; LW r12 (equal latency, ok) ; ADDU r12 (shorter, waits).
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd12);
        expect_is("waw_lw_a", 1'b1, 1'b0);
        cyc();
        expect_is("waw_lw_b", 1'b1, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd12);
        expect_is("waw_alu_wait", 1'b0, 1'b1);
        cyc();
        expect_is("waw_alu_go", 1'b1, 1'b0);
        cyc();
        idle();
        @(negedge clk);
        check_eq("waw_stall_cnt", stall_cnt, 32'd36);

        // 6: DIV ; LW r13 ; reset one cycle (pipeline frozen) ; ADDU, MFHI go.
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0);
        expect_is("t6_div", 1'b1, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd13);
        expect_is("t6_lw", 1'b1, 1'b0);
        cyc();
        rst_n = 1'b0;
        bus.ex_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd13, 5'd0, 5'd15);
        expect_is("t6_in_rst", 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
        bus.ex_ready = 1'b1;
        expect_is("t6_addu", 1'b1, 1'b0);
        check_eq("t6_div_busy", {31'd0, div_busy}, 32'd0);
        check_eq("t6_stall_cnt", stall_cnt, 32'd0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd14);
        expect_is("t6_mfhi", 1'b1, 1'b0);
        cyc();
        idle();
        @(negedge clk);
        check_eq("t6_end_stall_cnt", stall_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
